// File: rtl/fir_interp2.sv
// rtl/fir_interp2.sv - 2x polyphase interpolating FIR, 4-tap prototype, valid/ready streaming
//
// Purpose: each accepted input sample is shifted into a two-deep delay line
// (x0 newest, x1 previous). Two output samples follow: the even phase
// (COEF0*x0 + COEF2*x1) first, then the odd phase (COEF1*x0 + COEF3*x1).
// Each result is rounded half-up, shifted right by ROUND_SHIFT and saturated
// to OUT_WIDTH.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   in_data    signed input sample, IN_WIDTH bits
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   signed interpolated sample, OUT_WIDTH bits (0 while idle)
module fir_interp2 #(
   parameter int IN_WIDTH    = 8,
   parameter int OUT_WIDTH   = 8,
   parameter int COEF_WIDTH  = 3,
   parameter int COEF0       = 1,
   parameter int COEF1       = 2,
   parameter int COEF2       = 3,
   parameter int COEF3       = 4,
   parameter int ROUND_SHIFT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] out_data
);

   localparam int PROD_W = IN_WIDTH + COEF_WIDTH + 1;
   localparam int SUM_W  = IN_WIDTH + COEF_WIDTH + 2;
   // One extra bit so adding the rounding constant can never wrap.
   localparam int RND_W  = SUM_W + 1;

   // Coefficients are unsigned magnitudes; a zero sign bit makes them
   // usable directly in signed multiplies.
   localparam logic [COEF_WIDTH-1:0] C0_U = COEF_WIDTH'(COEF0);
   localparam logic [COEF_WIDTH-1:0] C1_U = COEF_WIDTH'(COEF1);
   localparam logic [COEF_WIDTH-1:0] C2_U = COEF_WIDTH'(COEF2);
   localparam logic [COEF_WIDTH-1:0] C3_U = COEF_WIDTH'(COEF3);

   localparam logic signed [COEF_WIDTH:0] C0 = signed'({1'b0, C0_U});
   localparam logic signed [COEF_WIDTH:0] C1 = signed'({1'b0, C1_U});
   localparam logic signed [COEF_WIDTH:0] C2 = signed'({1'b0, C2_U});
   localparam logic signed [COEF_WIDTH:0] C3 = signed'({1'b0, C3_U});

   localparam logic signed [RND_W-1:0] HALF    = RND_W'(1) <<< (ROUND_SHIFT - 1);
   localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH0  = 2'd1,
      PH1  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic signed [IN_WIDTH-1:0] x0_q, x0_d;
   logic signed [IN_WIDTH-1:0] x1_q, x1_d;

   logic signed [COEF_WIDTH:0] coef_new, coef_old;
   logic signed [PROD_W-1:0]   prod_new, prod_old;
   logic signed [SUM_W-1:0]    sum;
   logic signed [RND_W-1:0]    biased;
   logic signed [RND_W-1:0]    rounded;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x0_q    <= '0;
         x1_q    <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x0_d      = x0_q;
      x1_d      = x1_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         PH0: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = PH1;
            end
         end
         PH1: begin
            out_valid = 1'b1;
            // Taking a new sample while the odd phase drains keeps the
            // output stream free of bubbles.
            in_ready  = out_ready;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An accept always overrides the phase transition chosen above.
      if (in_valid && in_ready) begin
         x1_d    = x0_q;
         x0_d    = in_data;
         state_d = PH0;
      end
   end

   // Share one multiplier pair between the phases by selecting coefficients.
   always_comb begin
      coef_new = C0;
      coef_old = C2;
      if (state_q == PH1) begin
         coef_new = C1;
         coef_old = C3;
      end
   end

   always_comb begin
      prod_new = PROD_W'(x0_q) * PROD_W'(coef_new);
      prod_old = PROD_W'(x1_q) * PROD_W'(coef_old);
      sum      = SUM_W'(prod_new) + SUM_W'(prod_old);
      biased   = RND_W'(sum) + HALF;
      rounded  = biased >>> ROUND_SHIFT;
   end

   always_comb begin
      out_data = '0;
      if (state_q != IDLE) begin
         if (rounded > SAT_MAX) begin
            out_data = OUT_WIDTH'(SAT_MAX);
         end else if (rounded < SAT_MIN) begin
            out_data = OUT_WIDTH'(SAT_MIN);
         end else begin
            out_data = OUT_WIDTH'(rounded);
         end
      end
   end

endmodule

// File: tb/tb_fir_interp2.sv
// tb/tb_fir_interp2.sv - directed scoreboard bench for fir_interp2
module tb_fir_interp2;

   localparam int C0 = 1;
   localparam int C1 = 2;
   localparam int C2 = 3;
   localparam int C3 = 4;
   localparam int RS = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_data;

   int n_cmp = 0;
   int n_err = 0;
   int q[$];
   int mx0 = 0;
   int mx1 = 0;

   always #5 clk = ~clk;

   fir_interp2 #(
      .IN_WIDTH(8), .OUT_WIDTH(8), .COEF_WIDTH(3),
      .COEF0(C0), .COEF1(C1), .COEF2(C2), .COEF3(C3), .ROUND_SHIFT(RS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   function automatic int model_out(int sum);
      int r;
      r = (sum + (1 << (RS - 1))) >>> RS;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, update the scoreboard, then
   // return 1 ns after the rising edge so the caller can drive new inputs.
   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = 1'b0;
      if (rst) begin
         q.delete();
         mx0 = 0;
         mx1 = 0;
      end else begin
         check("out_valid", out_valid, q.size() != 0);
         check("in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
         if (q.size() != 0) check("out_data", out_data, q[0]);
         else               check("idle_data", out_data, 0);
         if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            acc = 1'b1;
            mx1 = mx0;
            mx0 = in_data;
            q.push_back(model_out(C0 * mx0 + C2 * mx1));
            q.push_back(model_out(C1 * mx0 + C3 * mx1));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = 8'(d);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         cycle(acc);
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         cycle(acc);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      cycle(acc);
   endtask

   task automatic do_reset();
      bit acc;
      rst = 1'b1;
      cycle(acc);
      rst = 1'b0;
   endtask

   initial begin
      bit acc;
      int n;
      int held;
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      @(posedge clk);
      #1;

      // 100 -> 25, 50 ; then -128 with x1=100 -> 43, 36
      send(100);
      drain();
      send(-128);
      drain();

      // 127 twice back-to-back: second accept coincides with the PH1 handshake
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'sd127;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin cycle(acc); n++; end
      check("b2b_first_accept", acc, 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin cycle(acc); n++; end
      check("no_bubble_gap", n, 2);
      in_valid = 1'b0;
      drain();

      // -128 twice: second pair saturates low
      send(-128);
      send(-128);
      drain();

      // Stall in PH0 then PH1 with in_valid pulses that must be ignored
      send(50);
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 8'sd77;
         cycle(acc);
         check("stall0_accept", acc, 0);
         check("stall0_hold", out_data, held);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle(acc);
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         in_valid = ~i[0];
         in_data  = -8'sd5;
         cycle(acc);
         check("stall1_accept", acc, 0);
         check("stall1_hold", out_data, held);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset while in PH1 aborts the pair and clears the delay line
      send(60);
      cycle(acc);
      rst = 1'b1;
      cycle(acc);
      rst = 1'b0;
      @(negedge clk);
      check("ph1_rst_out_valid", out_valid, 0);
      check("ph1_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      send(100);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
